// File: rtl/fw_local_intc_rr_claim.sv
// Round-robin claim/complete controller between a local interrupt controller's
// pending lines and a CPU. One source is offered at a time; once claimed it is
// held in service until the CPU completes it with the matching id.
module fw_local_intc_rr_claim #(
    parameter int N_SRCS = 8,
    parameter int ID_W   = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [N_SRCS-1:0] src,
    input  logic [N_SRCS-1:0] en,
    output logic              irq,
    output logic [ID_W-1:0]   irq_id,
    input  logic              claim_req,
    output logic              claim_ack,
    output logic              claim_valid,
    output logic [ID_W-1:0]   claim_id,
    input  logic              complete_req,
    input  logic [ID_W-1:0]   complete_id,
    output logic              complete_ack,
    output logic              complete_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARB    = 2'd1,
        S_OFFER  = 2'd2,
        S_ACTIVE = 2'd3
    } state_t;

    // Highest valid id; the pointer wraps to 0 after granting this one.
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_SRCS - 1);
    // Source count widened by one bit so pointer+offset sums can be reduced.
    localparam logic [ID_W:0]   N_WIDE  = (ID_W + 1)'(N_SRCS);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   winner_q, winner_d;
    logic [ID_W-1:0]   active_q, active_d;
    logic              irq_q, irq_d;
    logic [ID_W-1:0]   irq_id_q, irq_id_d;
    logic              claim_ack_q, claim_ack_d;
    logic              claim_valid_q, claim_valid_d;
    logic [ID_W-1:0]   claim_id_q, claim_id_d;
    logic              complete_ack_q, complete_ack_d;
    logic              complete_err_q, complete_err_d;
    logic              busy_q, busy_d;

    logic [N_SRCS-1:0] eligible;
    logic [N_SRCS-1:0] elig_rot;
    logic [ID_W-1:0]   cand_id [N_SRCS];
    logic [ID_W-1:0]   rr_winner;

    assign eligible = src & en;

    // Position gi of the search order maps to source (ptr + gi) mod N_SRCS;
    // elig_rot is the eligible vector viewed in that order.
    for (genvar gi = 0; gi < N_SRCS; gi++) begin : g_cand
        logic [ID_W:0] cand_sum;

        // Candidate id and its eligibility for this search position.
        always_comb begin
            cand_sum = {1'b0, ptr_q} + (ID_W + 1)'(gi);
            if (cand_sum >= N_WIDE) begin
                cand_sum = cand_sum - N_WIDE;
            end
            cand_id[gi]  = cand_sum[ID_W-1:0];
            elig_rot[gi] = eligible[cand_id[gi]];
        end
    end

    // First eligible source at or after the pointer wins (lowest search position).
    always_comb begin
        rr_winner = '0;
        for (int i = N_SRCS - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                rr_winner = cand_id[i];
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        winner_d       = winner_q;
        active_d       = active_q;
        claim_ack_d    = 1'b0;
        claim_valid_d  = 1'b0;
        claim_id_d     = '0;
        complete_ack_d = 1'b0;
        complete_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                // Requests may have vanished since IDLE saw them.
                if (|eligible) begin
                    winner_d = rr_winner;
                    state_d  = S_OFFER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OFFER: begin
                // A claim beats a same-cycle withdrawal of the offered source.
                if (claim_req) begin
                    active_d = winner_q;
                    ptr_d    = (winner_q == LAST_ID) ? '0 : winner_q + 1'b1;
                    state_d  = S_ACTIVE;
                end else if (!eligible[winner_q]) begin
                    state_d = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (complete_req && (complete_id == active_q)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every claim strobe is answered; it is only granted while offering.
        if (claim_req) begin
            claim_ack_d = 1'b1;
            if (state_q == S_OFFER) begin
                claim_valid_d = 1'b1;
                claim_id_d    = winner_q;
            end
        end

        // Every complete strobe is answered; only the in-service id is accepted.
        if (complete_req) begin
            complete_ack_d = 1'b1;
            complete_err_d = !((state_q == S_ACTIVE) && (complete_id == active_q));
        end

        irq_d    = (state_d == S_OFFER);
        irq_id_d = (state_d == S_OFFER) ? winner_d : '0;
        busy_d   = (state_d == S_ACTIVE);
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            winner_q       <= '0;
            active_q       <= '0;
            irq_q          <= 1'b0;
            irq_id_q       <= '0;
            claim_ack_q    <= 1'b0;
            claim_valid_q  <= 1'b0;
            claim_id_q     <= '0;
            complete_ack_q <= 1'b0;
            complete_err_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            winner_q       <= winner_d;
            active_q       <= active_d;
            irq_q          <= irq_d;
            irq_id_q       <= irq_id_d;
            claim_ack_q    <= claim_ack_d;
            claim_valid_q  <= claim_valid_d;
            claim_id_q     <= claim_id_d;
            complete_ack_q <= complete_ack_d;
            complete_err_q <= complete_err_d;
            busy_q         <= busy_d;
        end
    end

    assign irq          = irq_q;
    assign irq_id       = irq_id_q;
    assign claim_ack    = claim_ack_q;
    assign claim_valid  = claim_valid_q;
    assign claim_id     = claim_id_q;
    assign complete_ack = complete_ack_q;
    assign complete_err = complete_err_q;
    assign busy         = busy_q;

endmodule
